// File: rtl/cnt_arbiter.sv
// cnt_arbiter
//   Round-robin arbiter that shares the single counter read port among N_REQ
//   requesters. It serialises requests, returns the response to the winning
//   requester, and aborts a transaction that is not acknowledged within
//   TIMEOUT cycles. An aborted transaction returns 32'hDEAD_BEEF with s_err set.
//
// Ports
//   clock     : single clock
//   reset     : asynchronous, active-high reset
//   s_req     : per-requester request level            [N_REQ]
//   s_addr    : per-requester address, 32 bits each   [32*N_REQ]
//   s_ack     : one-cycle completion pulse             [N_REQ]
//   s_err     : one-cycle timeout flag, with s_ack     [N_REQ]
//   s_data    : shared response data, valid with s_ack [32]
//   m_req     : request to the counter region
//   m_addr    : address to the counter region          [32]
//   m_data    : counter data, valid with m_ack         [32]
//   m_ack     : one-cycle acknowledge from the counter region
//   busy      : a transaction is outstanding (GRANT or RESP)
//   grant_id  : index of the current or most recent grant [3]
module cnt_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     s_req,
  input  logic [32*N_REQ-1:0]  s_addr,
  output logic [N_REQ-1:0]     s_ack,
  output logic [N_REQ-1:0]     s_err,
  output logic [31:0]          s_data,
  output logic                 m_req,
  output logic [31:0]          m_addr,
  input  logic [31:0]          m_data,
  input  logic                 m_ack,
  output logic                 busy,
  output logic [2:0]           grant_id
);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  localparam logic [15:0]      CNT_LAST = 16'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_t               state, state_nxt;
  logic [2:0]           prio, prio_nxt;
  logic [2:0]           grant_nxt;
  logic [2:0]           winner;
  logic [15:0]          cnt, cnt_nxt;
  logic [N_REQ-1:0]     s_ack_nxt, s_err_nxt;
  logic [31:0]          s_data_nxt, m_addr_nxt;
  logic                 m_req_nxt;
  logic [32*N_REQ-1:0]  addr_shift;

  // First set request bit at or above base, wrapping around. The request
  // vector is doubled and shifted so bit 0 of the rotated view is base.
  function automatic logic [2:0] pick_winner(input logic [N_REQ-1:0] req,
                                             input logic [2:0]       base);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   tmp;
    logic [2:0]         w;
    logic               found;
    int                 idx;
    dbl   = {req, req};
    rot   = N_REQ'(dbl >> base);
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      tmp = rot >> k;
      if (!found && tmp[0]) begin
        idx = int'(base) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        w     = 3'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [2:0] next_prio(input logic [2:0] w);
    int w1;
    w1 = int'(w) + 1;
    return (w1 >= N_REQ) ? 3'd0 : 3'(w1);
  endfunction

  assign winner     = pick_winner(s_req, prio);
  assign addr_shift = s_addr >> (32 * int'(winner));
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    prio_nxt   = prio;
    grant_nxt  = grant_id;
    cnt_nxt    = cnt;
    m_req_nxt  = m_req;
    m_addr_nxt = m_addr;
    s_data_nxt = s_data;
    s_ack_nxt  = '0;
    s_err_nxt  = '0;
    unique case (state)
      IDLE: begin
        if (|s_req) begin
          state_nxt  = GRANT;
          grant_nxt  = winner;
          prio_nxt   = next_prio(winner);
          m_addr_nxt = addr_shift[31:0];
          m_req_nxt  = 1'b1;
          cnt_nxt    = '0;
        end
      end
      GRANT: begin
        // An ack in the last allowed cycle still wins over the abort.
        if (m_ack) begin
          state_nxt  = RESP;
          s_data_nxt = m_data;
          s_ack_nxt  = ONE_HOT0 << grant_id;
          m_req_nxt  = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = RESP;
          s_data_nxt = 32'hDEAD_BEEF;
          s_ack_nxt  = ONE_HOT0 << grant_id;
          s_err_nxt  = ONE_HOT0 << grant_id;
          m_req_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        m_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prio     <= '0;
      grant_id <= '0;
      cnt      <= '0;
      m_req    <= 1'b0;
      m_addr   <= '0;
      s_data   <= '0;
      s_ack    <= '0;
      s_err    <= '0;
    end else begin
      state    <= state_nxt;
      prio     <= prio_nxt;
      grant_id <= grant_nxt;
      cnt      <= cnt_nxt;
      m_req    <= m_req_nxt;
      m_addr   <= m_addr_nxt;
      s_data   <= s_data_nxt;
      s_ack    <= s_ack_nxt;
      s_err    <= s_err_nxt;
    end
  end

endmodule

// File: tb/tb_cnt_arbiter.sv
// Testbench for cnt_arbiter: directed steps followed by randomized
// transactions, checked against a transaction-level reference model.
module tb_cnt_arbiter;

  localparam int N  = 2;
  localparam int TO = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    s_req;
  logic [32*N-1:0] s_addr;
  logic [N-1:0]    s_ack, s_err;
  logic [31:0]     s_data;
  logic            m_req;
  logic [31:0]     m_addr;
  logic [31:0]     m_data;
  logic            m_ack;
  logic            busy;
  logic [2:0]      grant_id;

  int ncmp  = 0;
  int nfail = 0;
  int m_prio = 0;

  cnt_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .s_req(s_req), .s_addr(s_addr),
    .s_ack(s_ack), .s_err(s_err), .s_data(s_data), .m_req(m_req),
    .m_addr(m_addr), .m_data(m_data), .m_ack(m_ack), .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester at or after the priority pointer.
  function automatic int model_winner(input logic [N-1:0] mask);
    int idx;
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) begin
      idx = (m_prio + k) % N;
      t = mask >> idx;
      if (t[0]) return idx;
    end
    return 0;
  endfunction

  // One transaction from IDLE. d: cycles after m_req rises before m_ack is
  // driven (ack is high in GRANT cycle d+1). Returns at a negedge in IDLE.
  task automatic txn(input logic [N-1:0] mask, input logic [32*N-1:0] addrs,
                     input int d, input logic [31:0] data,
                     input bit withdraw, input bit keep, input bit late);
    int w, mcnt, resp_c;
    bit normal;
    logic [31:0] exp_addr, exp_data;
    logic [N-1:0] onehot;
    w        = model_winner(mask);
    exp_addr = 32'(addrs >> (32 * w));
    normal   = (d + 1 <= TO);
    exp_data = normal ? data : 32'hDEAD_BEEF;
    onehot   = N'(1) << w;
    m_prio   = (w + 1) % N;

    s_req = mask; s_addr = addrs; m_ack = 1'b0;
    tick();
    chk("grant_m_req", 32'(m_req), 32'd1);
    chk("grant_m_addr", m_addr, exp_addr);
    chk("grant_id", 32'(grant_id), 32'(w));
    chk("grant_busy", 32'(busy), 32'd1);
    if (withdraw) s_req = '0;

    mcnt = 0; resp_c = 0;
    for (int c = 1; c <= TO + 3 && resp_c == 0; c++) begin
      m_ack = 1'b0;
      if (s_ack != '0) resp_c = c;
      else begin
        if (m_req) mcnt++;
        if (c == d + 1) begin m_ack = 1'b1; m_data = data; end
        else m_data = $urandom;
        tick();
      end
    end
    m_ack = 1'b0;
    chk("resp_cycle", 32'(resp_c), 32'(normal ? d + 2 : TO + 1));
    chk("resp_s_ack", 32'(s_ack), 32'(onehot));
    chk("resp_s_err", 32'(s_err), normal ? 32'd0 : 32'(onehot));
    chk("resp_s_data", s_data, exp_data);
    chk("resp_m_req", 32'(m_req), 32'd0);
    chk("resp_busy", 32'(busy), 32'd1);
    chk("m_req_cycles", 32'(mcnt), 32'(normal ? d + 1 : TO));

    if (!keep) s_req = '0;
    if (late) begin m_ack = 1'b1; m_data = $urandom; end
    tick();
    chk("idle_s_ack", 32'(s_ack), 32'd0);
    chk("idle_s_err", 32'(s_err), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_m_req", 32'(m_req), 32'd0);
    chk("idle_s_data", s_data, exp_data);
    if (late) begin
      tick();
      m_ack = 1'b0;
      chk("late_m_req", 32'(m_req), 32'd0);
      chk("late_busy", 32'(busy), 32'd0);
      chk("late_s_ack", 32'(s_ack), 32'd0);
      chk("late_s_data", s_data, exp_data);
    end
    m_ack = 1'b0;
  endtask

  initial begin
    logic [N-1:0] mask;
    int d;
    bit wd, lt;
    reset = 1'b1; s_req = '0; s_addr = '0; m_ack = 1'b0; m_data = '0;
    #1;
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ack", 32'(s_ack), 32'd0);
    chk("rst_s_err", 32'(s_err), 32'd0);
    chk("rst_s_data", s_data, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Contention: both requesters held high, immediate ack -> 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      txn(2'b11, {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)}, 0, $urandom, 0, 1, 0);
      chk("contention_seq", 32'(grant_id), 32'(i % 2));
    end

    // Single request with ack one cycle after m_req.
    txn(2'b01, {32'h0, 32'h10}, 1, 32'h1234, 0, 0, 0);

    // Timeout with no ack, then late acks that must be ignored.
    txn(2'b01, {$urandom, $urandom}, TO + 5, $urandom, 0, 0, 1);

    // Ack in the final allowed cycle completes normally.
    txn(2'b10, {$urandom, $urandom}, TO - 1, 32'hCAFE_0001, 0, 0, 0);

    // Requester 1 withdraws after grant.
    txn(2'b10, {32'h0000_0077, 32'h0000_0055}, 2, 32'h5A5A_0002, 1, 0, 0);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      mask = N'($urandom_range(1, 3));
      d    = $urandom_range(0, TO + 1);
      wd   = 1'($urandom_range(0, 1));
      lt   = (d + 1 > TO) && ($urandom_range(0, 1) == 1);
      txn(mask, {$urandom, $urandom}, d, $urandom, wd, 0, lt);
    end

    // Reset in the middle of GRANT.
    s_req = 2'b10; s_addr = {32'h1111_2222, 32'h3333_4444};
    tick();
    chk("pre_rst_m_req", 32'(m_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_m_req", 32'(m_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_s_ack", 32'(s_ack), 32'd0);
    chk("midrst_grant_id", 32'(grant_id), 32'd0);
    s_req = '0;
    @(negedge clock);
    reset  = 1'b0;
    m_prio = 0;
    txn(2'b11, {32'h0000_00B1, 32'h0000_00A0}, 1, 32'h0BAD_F00D, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/cnt_arbiter.md
# cnt_arbiter

Round-robin arbiter that lets several requesters share the single assertion-counter read port (`req`/`addr`/`data`/`ack`) of `assertion_region`. It sits between the existing AXI-Lite counter bridge and further on-chip requesters, such as a debug scanner, and the counter port. It serialises requests, routes the response back to the winning requester, and aborts any transaction the counter region never acknowledges.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, 2..8.
- `TIMEOUT`, default 255: maximum number of cycles spent waiting for `m_ack` before the transaction is aborted, 1..65535.

Ports:
- `clock`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-high reset.
- `s_req`  in  N_REQ  per-requester request level.
- `s_addr`  in  32*N_REQ  per-requester counter address; requester i uses bits [32i+31:32i].
- `s_ack`  out  N_REQ  one-cycle completion pulse to the granted requester.
- `s_err`  out  N_REQ  one-cycle timeout flag, asserted together with `s_ack`.
- `s_data`  out  32  response data, shared by all requesters; valid only while `s_ack[i]` is high.
- `m_req`  out  1  request to the counter region.
- `m_addr`  out  32  address to the counter region.
- `m_data`  in  32  counter data; valid while `m_ack` is high.
- `m_ack`  in  1  one-cycle acknowledge from the counter region.
- `busy`  out  1  high whenever a transaction is outstanding.
- `grant_id`  out  3  index of the current or most recent grant.

## Operation
- Requester protocol:
  - Raise `s_req[i]` and hold `s_addr[i]` stable until `s_ack[i]` pulses.
  - Drop `s_req[i]` in the cycle after the ack, or keep it high to issue a new request.
- Counter-side protocol:
  - `m_req` is held high with `m_addr` stable until `m_ack` is sampled high.
  - `m_req` falls in the cycle after `m_ack`.
- State machine:
  - IDLE → GRANT when any `s_req` bit is set.
    - The winner is the first set bit searched upward from `prio` with wrap-around.
    - On the same edge: `grant_id` ← winner, `m_addr` ← `s_addr[winner]` (latched), `m_req` ← 1, timeout counter ← 0.
    - `prio` ← (winner+1) mod N_REQ.
  - GRANT, `m_ack` sampled high:
    - `s_data` ← `m_data`, `s_ack[grant_id]` ← 1, `m_req` ← 0.
    - Next state RESP.
  - GRANT, no ack:
    - The counter increments each cycle.
    - When it equals TIMEOUT−1 and `m_ack` is still low: `s_data` ← 32'hDEAD_BEEF, `s_ack[grant_id]` ← 1, `s_err[grant_id]` ← 1, `m_req` ← 0.
    - Next state RESP.
    - Abort has no priority over ack: if `m_ack` is high in that same cycle, the transaction completes normally with `s_err` = 0.
  - RESP → IDLE unconditionally.
    - `s_ack` and `s_err` return to 0.
    - `s_data` holds its value.
- Arbitration is not re-evaluated until IDLE. A requester that drops `s_req` after being granted still sees its transaction complete.
- An `m_ack` arriving while `m_req` is low (IDLE or RESP, e.g. a late ack after a timeout) is ignored.
- `busy` = 1 in GRANT and RESP.
- Unused `s_req` bits beyond N_REQ do not exist. `grant_id` bits above log2(N_REQ) are 0.

## Timing
- Reset (asynchronous, immediate): all outputs 0, `s_data` = 0, `m_addr` = 0, `grant_id` = 0, `prio` = 0, state IDLE, counter 0.
- Reset asserted mid-transaction: the transaction is dropped with no ack to the requester. The counter region is expected to be reset in the same domain.
- Request sampled at edge E0: `m_req` is high after E0.
- `m_ack` high in the cycle ending at edge Ek: `s_ack`/`s_data` are valid in the cycle after Ek. Total latency from `s_req` to `s_ack` is 2 + (counter-side ack delay) cycles.
- Minimum request-to-request spacing at the counter port: 3 cycles (GRANT, RESP, IDLE).
- Timeout:
  - With `m_req` first high in cycle 1 and no `m_ack`, `s_ack` and `s_err` are asserted in cycle TIMEOUT+1.
  - `m_req` is high for exactly TIMEOUT cycles.

## Test plan
- Single request: `s_req[0]`=1, `s_addr[0]`=0x10, `m_ack` returned one cycle after `m_req` with `m_data`=0x1234 → `m_addr`=0x10; `s_ack[0]` pulses one cycle with `s_data`=0x1234 and `s_err`=0; `busy` falls after RESP.
- Contention with N_REQ=2: both requesters held high continuously, `m_ack` always immediate → grants alternate 0,1,0,1 over four transactions; `grant_id` follows that sequence.
- Timeout with TIMEOUT=4: `m_ack` never asserted → `m_req` high for exactly 4 cycles; `s_ack[i]` and `s_err[i]` pulse together with `s_data`=0xDEADBEEF; a `m_ack` arriving 2 cycles later has no effect.
- Ack in the final timeout cycle: `m_ack` arrives in cycle TIMEOUT → normal completion, `s_err`=0, `s_data`=`m_data`.
- Requester withdraws: `s_req[1]` dropped after grant → `m_req` remains high until ack, and `s_ack[1]` still pulses.
- Reset mid-GRANT: `reset` asserted asynchronously with `m_req`=1 → `m_req`, `busy`, `s_ack` and `grant_id` go to 0 immediately; the first request after reset release is arbitrated from priority 0.
